// File: rtl/spi_mem_pkg.sv
// Shared types and defaults for the SPI memory request controller.
package spi_mem_pkg;

  localparam int ADDR_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RESP
  } state_t;

endpackage

// File: rtl/spi_mem_line.sv
// Single-entry write-through line buffer: one tag/data pair with a valid bit.
// Flush takes priority over a fill landing on the same edge.
module spi_mem_line
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_tag,
  input  logic [7:0]        fill_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [7:0]        hit_data
);

  logic              line_vld;
  logic [ADDR_W-1:0] line_tag;
  logic [7:0]        line_data;

  // Valid bit: cleared by reset or flush, set by a fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_vld <= 1'b0;
    end else if (flush) begin
      line_vld <= 1'b0;
    end else if (fill) begin
      line_vld <= 1'b1;
    end
  end

  // Tag and data payload; only meaningful while line_vld is set.
  always_ff @(posedge clk) begin
    if (fill) begin
      line_tag  <= fill_tag;
      line_data <= fill_data;
    end
  end

  assign hit      = CACHE_EN && line_vld && (line_tag == lookup_addr);
  assign hit_data = line_data;

endmodule

// File: rtl/spi_mem_ctrl.sv
// CPU-side request controller in front of the SPI SRAM master. One SPI
// transaction per request, operands frozen in registers for its duration,
// repeated reads of the buffered address answered locally.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  input  logic              flush,
  output logic              spi_start,
  output logic              spi_write,
  output logic [ADDR_W-1:0] spi_address,
  output logic [7:0]        spi_wdata,
  input  logic              spi_done,
  input  logic [7:0]        spi_rdata
);

  state_t            state;
  state_t            state_nxt;
  logic              op_write;
  logic [ADDR_W-1:0] op_addr;
  logic [7:0]        op_wdata;
  logic              line_hit;
  logic [7:0]        line_data;
  logic              accept;
  logic              fill;
  logic [7:0]        fill_data;

  assign accept    = (state == IDLE) && req_valid;
  assign fill      = (state == WAIT_DONE) && spi_done;
  assign fill_data = op_write ? op_wdata : spi_rdata;

  spi_mem_line #(
    .ADDR_W   (ADDR_W),
    .CACHE_EN (CACHE_EN)
  ) u_line (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .fill        (fill),
    .fill_tag    (op_addr),
    .fill_data   (fill_data),
    .lookup_addr (req_addr),
    .hit         (line_hit),
    .hit_data    (line_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs. Start is only offered while the
  // master reports idle so it forms a single-cycle pulse.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    spi_start = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = (!req_write && line_hit) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        spi_start = spi_done;
        if (spi_done) state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!spi_done) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (spi_done) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers: captured at accept, held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_write <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
    end else if (accept) begin
      op_write <= req_write;
      op_addr  <= req_addr;
      op_wdata <= req_wdata;
    end
  end

  // Read data: from the line on a hit, from the master on a read completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
    end else if (accept && !req_write && line_hit) begin
      rsp_rdata <= line_data;
    end else if (fill && !op_write) begin
      rsp_rdata <= spi_rdata;
    end
  end

  assign spi_write   = op_write;
  assign spi_address = op_addr;
  assign spi_wdata   = op_wdata;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl with a small behavioural SPI master model.
module tb_spi_mem_ctrl;

  localparam int AW      = 16;
  localparam int SPI_LEN = 4;  // cycles the model holds done low
  // Miss latency (rsp cycle index after accept): start cycle, SPI_LEN busy
  // cycles, done-high cycle, then RESP -> SPI_LEN + 3.
  localparam int MISS_LAT = SPI_LEN + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_wdata;
  logic          rsp_valid;
  logic [7:0]    rsp_rdata;
  logic          flush;
  logic          spi_start;
  logic          spi_write;
  logic [AW-1:0] spi_address;
  logic [7:0]    spi_wdata;
  logic          spi_done = 1'b1;
  logic [7:0]    spi_rdata = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  spi_mem_ctrl #(
    .ADDR_W   (AW),
    .CACHE_EN (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .flush       (flush),
    .spi_start   (spi_start),
    .spi_write   (spi_write),
    .spi_address (spi_address),
    .spi_wdata   (spi_wdata),
    .spi_done    (spi_done),
    .spi_rdata   (spi_rdata)
  );

  always #5 clk = ~clk;

  // SPI master model state and activity monitors
  logic [7:0]    mem [0:255];
  int            m_cnt = 0;
  logic          m_write = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_wdata = '0;
  int            start_cnt = 0;
  int            rsp_cnt = 0;
  int            stab_err = 0;
  int            start_err = 0;

  function automatic logic [7:0] init_val(input int a);
    logic [7:0] v;
    v = a[7:0] ^ 8'hFF;
    case (a)
      8'h34:   v = 8'hA5;
      8'h02:   v = 8'h5A;
      8'h10:   v = 8'hC3;
      default: ;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    if (spi_start) start_cnt <= start_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (spi_start && !spi_done) start_err <= start_err + 1;
    if (!rst && !spi_done &&
        (spi_address !== m_addr || spi_write !== m_write || spi_wdata !== m_wdata))
      stab_err <= stab_err + 1;
    if (rst) begin
      spi_done  <= 1'b1;
      spi_rdata <= 8'h00;
      m_cnt     <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (spi_done && spi_start) begin
      spi_done <= 1'b0;
      m_cnt    <= SPI_LEN;
      m_write  <= spi_write;
      m_addr   <= spi_address;
      m_wdata  <= spi_wdata;
    end else if (!spi_done) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        spi_done <= 1'b1;
        if (m_write) mem[m_addr[7:0]] <= m_wdata;
        else         spi_rdata <= mem[m_addr[7:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, return read data and rsp latency (cycles after accept).
  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
  endtask

  task automatic wait_done_level(input logic lvl);
    int n;
    n = 0;
    while (spi_done !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_spi_done_bound", 32'(n < 100), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int lat, s0, r0, n, rdy_err, op_err;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_spi_start", spi_start, 0);
    check("rst_spi_write", spi_write, 0);
    check("rst_spi_address", spi_address, 0);
    check("rst_spi_wdata", spi_wdata, 0);
    rst = 1'b0;

    // read miss
    s0 = start_cnt; r0 = rsp_cnt;
    do_req(1'b0, 16'h1234, 8'h00, rd, lat);
    check("miss_rdata", rd, 8'hA5);
    check("miss_latency", lat, MISS_LAT);
    check("miss_starts", start_cnt - s0, 1);
    check("miss_spi_addr", m_addr, 16'h1234);
    check("miss_spi_write", m_write, 0);
    @(negedge clk);
    check("miss_rsp_1cyc", rsp_valid, 0);
    check("miss_rsp_count", rsp_cnt - r0, 1);

    // read hit
    s0 = start_cnt; r0 = rsp_cnt;
    do_req(1'b0, 16'h1234, 8'h00, rd, lat);
    check("hit_rdata", rd, 8'hA5);
    check("hit_latency", lat, 1);
    check("hit_starts", start_cnt - s0, 0);
    @(negedge clk);
    check("hit_rsp_1cyc", rsp_valid, 0);
    check("hit_ready_again", req_ready, 1);
    check("hit_rsp_count", rsp_cnt - r0, 1);

    // write-through then hit
    s0 = start_cnt; r0 = rsp_cnt;
    do_req(1'b1, 16'h1234, 8'h3C, rd, lat);
    check("wr_latency", lat, MISS_LAT);
    check("wr_starts", start_cnt - s0, 1);
    check("wr_spi_write", m_write, 1);
    check("wr_spi_wdata", m_wdata, 8'h3C);
    check("wr_spi_addr", m_addr, 16'h1234);
    @(negedge clk);
    check("wr_rsp_count", rsp_cnt - r0, 1);
    s0 = start_cnt;
    do_req(1'b0, 16'h1234, 8'h00, rd, lat);
    check("wr_hit_rdata", rd, 8'h3C);
    check("wr_hit_latency", lat, 1);
    check("wr_hit_starts", start_cnt - s0, 0);

    // flush then miss (memory now holds the written byte)
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    s0 = start_cnt;
    do_req(1'b0, 16'h1234, 8'h00, rd, lat);
    check("flush_miss_starts", start_cnt - s0, 1);
    check("flush_miss_latency", lat, MISS_LAT);
    check("flush_miss_rdata", rd, 8'h3C);

    // flush coincident with fill
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
    @(negedge clk);
    req_valid = 1'b0;
    wait_done_level(1'b0);
    wait_done_level(1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("ff_rsp_valid", rsp_valid, 1);
    check("ff_rdata", rsp_rdata, 8'hC3);
    s0 = start_cnt;
    do_req(1'b0, 16'h0010, 8'h00, rd, lat);
    check("ff_reread_starts", start_cnt - s0, 1);
    check("ff_reread_rdata", rd, 8'hC3);

    // back-pressure: second request held during an active write
    s0 = start_cnt; rdy_err = 0; op_err = 0; n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h1234; req_wdata = 8'h77;
    @(negedge clk);
    req_write = 1'b0; req_addr = 16'h0002; req_wdata = 8'h00;
    while (!rsp_valid && n < 100) begin
      if (req_ready) rdy_err++;
      if (spi_address !== 16'h1234 || spi_write !== 1'b1 || spi_wdata !== 8'h77) op_err++;
      @(negedge clk);
      n++;
    end
    check("bp_ready_low", rdy_err, 0);
    check("bp_operands", op_err, 0);
    check("bp_ready_in_resp", req_ready, 0);
    @(negedge clk);
    check("bp_ready_after", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_second_latency", lat, MISS_LAT);
    check("bp_second_rdata", rsp_rdata, 8'h5A);
    check("bp_starts", start_cnt - s0, 2);

    // reset during WAIT_DONE
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
    @(negedge clk);
    req_valid = 1'b0;
    wait_done_level(1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_req_ready", req_ready, 1);
    check("mrst_spi_start", spi_start, 0);
    check("mrst_rsp_valid", rsp_valid, 0);
    r0 = rsp_cnt;
    repeat (10) @(negedge clk);
    check("mrst_no_rsp", rsp_cnt - r0, 0);
    s0 = start_cnt;
    do_req(1'b0, 16'h0002, 8'h00, rd, lat);
    check("mrst_line_invalid", start_cnt - s0, 1);
    check("mrst_rdata", rd, 8'h5A);

    check("spi_operand_stability", stab_err, 0);
    check("spi_start_only_idle", start_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
